shift_register4: RTL and testbench



---
 rtl/shift_register4_if.sv | 32 +++
 rtl/shift_register4.sv | 39 +++
 tb/tb_shift_register4.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/shift_register4_if.sv
// Purpose : serial-in / parallel-out bus bundle for shift_register4.
// Latency : n/a (wiring only).
// Backpressure: none; the register shifts on every clock edge.
//
// Signals:
//   x       serial data input (driven by master)
//   Q0..Q3  parallel taps, Q0 newest sample, Q3 oldest (driven by slave)
interface shift_register4_if;
  logic x;
  logic Q0;
  logic Q1;
  logic Q2;
  logic Q3;

  // Producer of serial data / consumer of the taps.
  modport master (
    output x,
    input  Q0,
    input  Q1,
    input  Q2,
    input  Q3
  );

  // The shift register itself.
  modport slave (
    input  x,
    output Q0,
    output Q1,
    output Q2,
    output Q3
  );
endinterface

// File: rtl/shift_register4.sv
// Purpose : 4-stage serial-in, parallel-out shift register (delay line).
// Latency : x reaches Q0 after 1 edge, Q1 after 2, Q2 after 3, Q3 after 4.
// Backpressure: none; shifts unconditionally on every rising clk edge.
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   n_rst  asynchronous active-low reset, loads RESET_VALUE into {Q3,Q2,Q1,Q0}
//   sr     slave side of shift_register4_if (x in, Q0..Q3 out)
module shift_register4 #(
  // Bit 0 maps to Q0, bit 3 maps to Q3.
  parameter logic [3:0] RESET_VALUE = 4'b0000
) (
  input  logic             clk,
  input  logic             n_rst,
  shift_register4_if.slave sr
);

  // r_stage[0] is the newest sample, r_stage[3] the oldest.
  logic [3:0] r_stage;
  logic [3:0] w_stage_nxt;

  // Oldest sample falls off the top; no wrap-around into stage 0.
  assign w_stage_nxt = {r_stage[2:0], sr.x};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_stage <= RESET_VALUE;
    end else begin
      r_stage <= w_stage_nxt;
    end
  end

  // Outputs come straight from flops: no combinational path from x.
  assign sr.Q0 = r_stage[0];
  assign sr.Q1 = r_stage[1];
  assign sr.Q2 = r_stage[2];
  assign sr.Q3 = r_stage[3];

endmodule

// File: tb/tb_shift_register4.sv
// Purpose : self-checking bench for shift_register4 with a scoreboard queue.
// Latency : expectations are pushed at each rising edge and compared 1 time unit later.
// Backpressure: n/a.
module tb_shift_register4;
  localparam logic [3:0] RV  = 4'b0000;
  localparam logic [3:0] RV2 = 4'b0110;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       x;
  logic [3:0] q;
  logic [3:0] q2;
  logic [3:0] model;
  logic [3:0] exp_q[$];
  logic [3:0] hold;
  logic [0:10] mix_pat;
  int         n_vec = 0;
  int         n_err = 0;

  shift_register4_if sr_if();
  shift_register4_if sr2_if();

  assign sr_if.x  = x;
  assign sr2_if.x = x;

  shift_register4 #(.RESET_VALUE(RV)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .sr    (sr_if)
  );

  // Second instance with a non-zero reset pattern to check bit-to-tap mapping.
  shift_register4 #(.RESET_VALUE(RV2)) dut2 (
    .clk   (clk),
    .n_rst (n_rst),
    .sr    (sr2_if)
  );

  assign q  = {sr_if.Q3,  sr_if.Q2,  sr_if.Q1,  sr_if.Q0};
  assign q2 = {sr2_if.Q3, sr2_if.Q2, sr2_if.Q1, sr2_if.Q0};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", tag, got, want);
    end
  endtask

  // One rising edge: update the reference model, queue its result,
  // then compare the DUT 1 time unit after the edge.
  task automatic tick(input string tag);
    logic [3:0] e;
    @(posedge clk);
    if (n_rst) model = {model[2:0], x};
    else       model = RV;
    exp_q.push_back(model);
    #1;
    e = exp_q.pop_front();
    chk(tag, q, e);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    model   = RV;
    mix_pat = 11'b0_1001_1100_01;

    // Reset held across the edge at t=5 with x=1.
    n_rst = 1'b0;
    x     = 1'b1;
    tick("rst_edge");                 // t=6
    chk("rst_const", q, 4'b0000);
    chk("rst_rv2", q2, RV2);
    #1 n_rst = 1'b1;                  // t=7
    #1;                               // t=8
    chk("rst_release", q, 4'b0000);

    // Single pulse: x=1 sampled only at t=15.
    tick("pulse_e1");                 // t=16
    chk("pulse_q0", q, 4'b0001);
    x = 1'b0;
    tick("pulse_e2");
    chk("pulse_q1", q, 4'b0010);
    tick("pulse_e3");
    chk("pulse_q2", q, 4'b0100);
    tick("pulse_e4");
    chk("pulse_q3", q, 4'b1000);
    tick("pulse_e5");
    chk("pulse_gone", q, 4'b0000);

    // Saturation then flush.
    x = 1'b1;
    for (int i = 0; i < 4; i++) tick("sat_fill");
    chk("sat_1111", q, 4'b1111);
    x = 1'b0;
    tick("flush1");
    chk("flush_1110", q, 4'b1110);
    tick("flush2");
    chk("flush_1100", q, 4'b1100);
    tick("flush3");
    chk("flush_1000", q, 4'b1000);
    tick("flush4");
    chk("flush_0000", q, 4'b0000);

    // Mixed pattern, one sampled bit per edge.
    for (int i = 0; i < 11; i++) begin
      x = mix_pat[i];
      tick("mix");
      if (i == 4)  chk("mix_1001", q, 4'b1001);
      if (i == 7)  chk("mix_1110", q, 4'b1110);
      if (i == 10) chk("mix_0001", q, 4'b0001);
    end

    // Async reset mid-stream from 1111.
    x = 1'b1;
    for (int i = 0; i < 4; i++) tick("refill");
    chk("refill_1111", q, 4'b1111);
    #2 n_rst = 1'b0;                  // between edges
    model = RV;
    #1;
    chk("arst_now", q, 4'b0000);
    chk("arst_rv2", q2, RV2);
    tick("arst_hold_edge");
    chk("arst_hold", q, 4'b0000);
    #2 n_rst = 1'b1;                  // release between edges, x still 1
    #1;
    chk("arst_release", q, 4'b0000);

    // Glitch immunity: Q0 becomes 1, then x toggles and settles at 0.
    tick("glitch_pre");
    chk("glitch_pre", q, 4'b0001);
    hold = q;
    x = 1'b0; #1 x = 1'b1; #1 x = 1'b0; #1 x = 1'b1;
    chk("glitch_mid", q, hold);
    #1 x = 1'b0;
    tick("glitch_edge");
    chk("glitch_q0", q, 4'b0010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
